// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - masked, priority-encoded interrupt controller with CPU req/ack/reti handshake
// Lowest pending index wins; the vector is frozen from request until the block returns to idle.
module irq_arbiter #(
  parameter int ADDRESS           = 0,
  parameter int BUS_ADDR_DATA_LEN = 16,
  parameter int NUM_INTS          = 8,
  parameter int VECTOR_WIDTH      = 5
) (
  input  logic                         clk,
  input  logic                         int_rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr_w,
  input  logic                         rd_w,
  input  logic [31:0]                  bus_in,
  output logic [31:0]                  bus_out,
  output logic                         req_bus,
  input  logic [NUM_INTS-1:0]          int_src,
  output logic [NUM_INTS-1:0]          int_ack,
  input  logic                         cpu_gie,
  output logic                         cpu_int_req,
  output logic [VECTOR_WIDTH-1:0]      cpu_int_vect,
  input  logic                         cpu_int_ack,
  input  logic                         cpu_reti
);

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

  localparam int AW = BUS_ADDR_DATA_LEN;
  localparam logic [AW:0] base_addr = (AW+1)'(ADDRESS);
  localparam logic [AW:0] end_addr  = base_addr + (AW+1)'(16);

  state_t                  state;
  logic [NUM_INTS-1:0]     mask;
  logic [NUM_INTS-1:0]     pending;
  logic [31:0]             pend32;
  logic [VECTOR_WIDTH-1:0] sel;
  logic [31:0]             status;
  logic [31:0]             rdata;
  logic [AW:0]             addr_ext;
  logic                    mask_wr;
  logic                    unused_bus;

  assign addr_ext   = {1'b0, addr};
  assign req_bus    = (addr_ext >= base_addr) && (addr_ext < end_addr);
  assign mask_wr    = wr_w && req_bus && (addr[3:0] == 4'h0);
  assign unused_bus = ^bus_in;

  assign pending = int_src & mask;
  assign pend32  = 32'(pending);

  always_comb begin
    sel = '0;
    for (int i = NUM_INTS - 1; i >= 0; i--) begin
      if (pending[i]) sel = VECTOR_WIDTH'(i);
    end
  end

  always_comb begin
    status    = 32'(cpu_int_vect);
    status[7] = (state != IDLE);
  end

  always_comb begin
    case (addr[3:0])
      4'h0:    rdata = 32'(mask);
      4'h4:    rdata = pend32;
      4'h8:    rdata = status;
      default: rdata = 32'h0;
    endcase
  end

  assign bus_out = (rd_w && req_bus) ? rdata : 32'h0;

  always_ff @(posedge clk or posedge int_rst) begin
    if (int_rst) begin
      mask <= '0;
    end else if (mask_wr) begin
      mask <= bus_in[NUM_INTS-1:0];
    end
  end

  // The IDLE decision sees the mask from before any same-cycle write.
  always_ff @(posedge clk or posedge int_rst) begin
    if (int_rst) begin
      state        <= IDLE;
      cpu_int_req  <= 1'b0;
      cpu_int_vect <= '0;
      int_ack      <= '0;
    end else begin
      int_ack <= '0;
      case (state)
        IDLE: begin
          if (cpu_gie && (pending != '0)) begin
            cpu_int_vect <= sel;
            cpu_int_req  <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (cpu_int_ack) begin
            int_ack     <= NUM_INTS'(1) << cpu_int_vect;
            cpu_int_req <= 1'b0;
            state       <= ACTIVE;
          end else if (!pend32[cpu_int_vect]) begin
            cpu_int_req <= 1'b0;
            state       <= IDLE;
          end
        end
        ACTIVE: begin
          if (cpu_reti) state <= IDLE;
        end
        default: begin
          cpu_int_req <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
